// File: rtl/axi_req_arbiter_if.sv
// AXI3 master-side bus bundle used between the CPU request arbiter and the
// system interconnect.
interface axi_req_arbiter_if;
   // AR channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   // R channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   // AW channel
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   // W channel
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   // B channel
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_req_arbiter.sv
// Arbitrates the CPU fetch and data request ports onto one AXI3 master,
// one transaction in flight per channel, data reads ahead of fetches.
module axi_req_arbiter #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   axi_req_arbiter_if.master axi
);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;

   r_state_e    r_state_q, r_state_d;
   w_state_e    w_state_q, w_state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic [31:0] ar_addr_q;
   logic [1:0]  ar_size_q;
   logic [3:0]  ar_id_q;
   logic [31:0] aw_addr_q;
   logic [1:0]  aw_size_q;
   logic [3:0]  w_strb_q;
   logic [31:0] w_data_q;

   logic        r_beat;
   logic        r_free;
   logic        data_rd_busy;
   logic        data_rd_acc;
   logic        rd_acc;
   logic        wr_acc;

   logic        arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;

   // The completing R beat frees the read channel in the same cycle, so a new
   // read may be accepted back-to-back.
   assign r_beat       = (r_state_q == R_WAIT) && axi.rvalid && axi.rlast;
   assign r_free       = (r_state_q == R_IDLE) || r_beat;
   assign data_rd_busy = (r_state_q != R_IDLE) && (ar_id_q == DATA_ID) && !r_beat;

   assign data_addr_ok = data_req && !data_rd_busy && (w_state_q == W_IDLE)
                         && (data_wr || r_free);
   assign data_rd_acc  = data_addr_ok && !data_wr;
   assign inst_addr_ok = inst_req && r_free && !data_rd_acc;
   assign rd_acc       = data_rd_acc || inst_addr_ok;
   assign wr_acc       = data_addr_ok && data_wr;

   // ---------------- read FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
      end else begin
         r_state_q <= r_state_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (rd_acc) r_state_d = R_AR;
         R_AR:    if (axi.arready) r_state_d = R_WAIT;
         R_WAIT:  if (r_beat) r_state_d = rd_acc ? R_AR : R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      arvalid_o = (r_state_q == R_AR);
      rready_o  = (r_state_q == R_WAIT);
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      case (w_state_q)
         W_IDLE:  if (wr_acc) w_state_d = W_ADDR;
         W_ADDR: begin
            if ((aw_done_q || axi.awready) && (w_done_q || axi.wready)) begin
               w_state_d = W_RESP;
            end else begin
               // AW and W complete independently; remember whichever is done
               aw_done_d = aw_done_q || axi.awready;
               w_done_d  = w_done_q || axi.wready;
            end
         end
         W_RESP:  if (axi.bvalid) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awvalid_o = (w_state_q == W_ADDR) && !aw_done_q;
      wvalid_o  = (w_state_q == W_ADDR) && !w_done_q;
      bready_o  = (w_state_q == W_RESP);
   end

   // ---------------- request capture ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ar_addr_q <= 32'h0;
         ar_size_q <= 2'b0;
         ar_id_q   <= 4'h0;
         aw_addr_q <= 32'h0;
         aw_size_q <= 2'b0;
         w_strb_q  <= 4'h0;
         w_data_q  <= 32'h0;
      end else begin
         if (rd_acc) begin
            ar_addr_q <= data_rd_acc ? data_addr : inst_addr;
            ar_size_q <= data_rd_acc ? data_size : inst_size;
            ar_id_q   <= data_rd_acc ? DATA_ID : INST_ID;
         end
         if (wr_acc) begin
            aw_addr_q <= data_addr;
            aw_size_q <= data_size;
            w_strb_q  <= data_wstrb;
            w_data_q  <= data_wdata;
         end
      end
   end

   // ---------------- AXI outputs ----------------
   assign axi.arid    = ar_id_q;
   assign axi.araddr  = ar_addr_q;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = {1'b0, ar_size_q};
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_o;
   assign axi.rready  = rready_o;

   assign axi.awid    = DATA_ID;
   assign axi.awaddr  = aw_addr_q;
   assign axi.awlen   = 4'd0;
   assign axi.awsize  = {1'b0, aw_size_q};
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'd0;
   assign axi.awprot  = 3'd0;
   assign axi.awvalid = awvalid_o;

   assign axi.wid     = DATA_ID;
   assign axi.wdata   = w_data_q;
   assign axi.wstrb   = w_strb_q;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = wvalid_o;
   assign axi.bready  = bready_o;

   // ---------------- response routing ----------------
   assign inst_data_ok = axi.rvalid && rready_o && (axi.rid != DATA_ID);
   assign data_data_ok = (axi.rvalid && rready_o && (axi.rid == DATA_ID))
                         || (axi.bvalid && bready_o);
   assign inst_rdata   = axi.rdata;
   assign data_rdata   = axi.rdata;

   // Response status and bid carry nothing the CPU ports can report.
   logic unused_resp;
   assign unused_resp = ^{axi.rresp, axi.bresp, axi.bid};

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Randomised bench for axi_req_arbiter: a transaction-level model of both ports
// and a randomly stalling AXI slave predict every handshake and response.
module tb_axi_req_arbiter;
   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        inst_req = 1'b0;
   logic [1:0]  inst_size = '0;
   logic [31:0] inst_addr = '0;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [1:0]  data_size = '0;
   logic [31:0] data_addr = '0;
   logic [3:0]  data_wstrb = '0;
   logic [31:0] data_wdata = '0;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   axi_req_arbiter_if axi();

   axi_req_arbiter #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .inst_req     (inst_req),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .axi          (axi)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction-level model: which port owns the read channel, whether a
   // write is in flight, and which address phases have already been taken.
   bit          rd_busy, rd_port, ar_done;
   logic [31:0] m_ar_addr;
   logic [2:0]  m_ar_size;
   logic [3:0]  m_ar_id;
   bit          wr_busy, aw_done, w_done;
   logic [31:0] m_aw_addr, m_w_data;
   logic [2:0]  m_aw_size;
   logic [3:0]  m_w_strb;
   bit          rvalid_drv, bvalid_drv, drop_inst, drop_data;
   logic [31:0] rdata_drv;

   task automatic idle_inputs();
      inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
      axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
      axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
      axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
   endtask

   task automatic reset_and_check(input string tag);
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check({tag, "_arvalid"}, axi.arvalid, 0);
      check({tag, "_awvalid"}, axi.awvalid, 0);
      check({tag, "_wvalid"},  axi.wvalid, 0);
      check({tag, "_rready"},  axi.rready, 0);
      check({tag, "_bready"},  axi.bready, 0);
      check({tag, "_araddr"},  axi.araddr, 0);
      check({tag, "_awaddr"},  axi.awaddr, 0);
      check({tag, "_wdata"},   axi.wdata, 0);
      check({tag, "_inst_ok"}, {inst_addr_ok, inst_data_ok}, 0);
      check({tag, "_data_ok"}, {data_addr_ok, data_data_ok}, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   initial begin
      bit r_free, data_rd_out, e_daok, e_iaok, e_idok, e_ddok;

      idle_inputs();
      #1;
      reset_and_check("reset");

      // ---------------- randomised phase ----------------
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge aclk); #1;
         if (drop_inst) inst_req = 1'b0;
         if (drop_data) data_req = 1'b0;
         if (!inst_req && $urandom_range(0, 1) == 0) begin
            inst_req  = 1'b1;
            inst_addr = $urandom;
            inst_size = 2'($urandom_range(0, 2));
         end
         if (!data_req && $urandom_range(0, 1) == 0) begin
            data_req   = 1'b1;
            data_wr    = 1'($urandom_range(0, 1));
            data_addr  = $urandom;
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom);
            data_wdata = $urandom;
         end
         axi.arready = 1'($urandom_range(0, 1));
         axi.awready = 1'($urandom_range(0, 1));
         axi.wready  = 1'($urandom_range(0, 2) == 0);
         if (!rvalid_drv && rd_busy && ar_done && $urandom_range(0, 1) == 1) begin
            rvalid_drv = 1'b1;
            rdata_drv  = $urandom;
         end
         if (!bvalid_drv && wr_busy && aw_done && w_done && $urandom_range(0, 1) == 1)
            bvalid_drv = 1'b1;
         axi.rvalid = rvalid_drv;
         axi.rid    = m_ar_id;
         axi.rdata  = rvalid_drv ? rdata_drv : 32'h0;
         axi.rlast  = rvalid_drv;
         axi.rresp  = 2'($urandom);
         axi.bvalid = bvalid_drv;
         axi.bid    = DATA_ID;
         axi.bresp  = 2'($urandom);

         @(negedge aclk);
         r_free      = !rd_busy || rvalid_drv;
         data_rd_out = rd_busy && rd_port && !rvalid_drv;
         e_daok = data_req && !data_rd_out && !wr_busy && (data_wr || r_free);
         e_iaok = inst_req && r_free && !(data_req && !data_wr && e_daok);
         e_idok = rvalid_drv && !rd_port;
         e_ddok = (rvalid_drv && rd_port) || bvalid_drv;

         check("data_addr_ok", data_addr_ok, e_daok);
         check("inst_addr_ok", inst_addr_ok, e_iaok);
         check("arvalid", axi.arvalid, rd_busy && !ar_done);
         check("rready",  axi.rready,  rd_busy && ar_done);
         check("awvalid", axi.awvalid, wr_busy && !aw_done);
         check("wvalid",  axi.wvalid,  wr_busy && !w_done);
         check("bready",  axi.bready,  wr_busy && aw_done && w_done);
         check("inst_data_ok", inst_data_ok, e_idok);
         check("data_data_ok", data_data_ok, e_ddok);
         if (e_idok) check("inst_rdata", inst_rdata, rdata_drv);
         if (e_ddok && rvalid_drv) check("data_rdata", data_rdata, rdata_drv);

         if (rd_busy && !ar_done && axi.arready) begin
            check("araddr", axi.araddr, m_ar_addr);
            check("arsize", axi.arsize, m_ar_size);
            check("arid",   axi.arid,   m_ar_id);
            check("ar_fixed", {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                  {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            ar_done = 1'b1;
         end
         if (wr_busy && !aw_done && axi.awready) begin
            check("awaddr", axi.awaddr, m_aw_addr);
            check("awsize", axi.awsize, m_aw_size);
            check("awid",   axi.awid,   DATA_ID);
            check("aw_fixed", {axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                  {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            aw_done = 1'b1;
         end
         if (wr_busy && !w_done && axi.wready) begin
            check("wdata", axi.wdata, m_w_data);
            check("wstrb", axi.wstrb, m_w_strb);
            check("wid_wlast", {axi.wid, axi.wlast}, {DATA_ID, 1'b1});
            w_done = 1'b1;
         end
         if (rvalid_drv) begin
            rd_busy = 1'b0; ar_done = 1'b0; rvalid_drv = 1'b0;
         end
         if (bvalid_drv) begin
            wr_busy = 1'b0; bvalid_drv = 1'b0;
         end
         if (e_daok && data_wr) begin
            wr_busy = 1'b1; aw_done = 1'b0; w_done = 1'b0;
            m_aw_addr = data_addr; m_aw_size = {1'b0, data_size};
            m_w_strb = data_wstrb; m_w_data = data_wdata;
         end
         if (e_daok && !data_wr) begin
            rd_busy = 1'b1; rd_port = 1'b1; ar_done = 1'b0;
            m_ar_addr = data_addr; m_ar_size = {1'b0, data_size}; m_ar_id = DATA_ID;
         end
         if (e_iaok) begin
            rd_busy = 1'b1; rd_port = 1'b0; ar_done = 1'b0;
            m_ar_addr = inst_addr; m_ar_size = {1'b0, inst_size}; m_ar_id = INST_ID;
         end
         drop_inst = e_iaok;
         drop_data = e_daok;
      end

      // ---------------- reset in the middle of a fetch ----------------
      @(posedge aclk); #1;
      idle_inputs();
      reset_and_check("reset2");
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; axi.arready = 1'b1;
      @(negedge aclk);
      check("mr_addr_ok", inst_addr_ok, 1);
      @(posedge aclk); #1;
      inst_req = 1'b0;
      @(negedge aclk);
      check("mr_arvalid", axi.arvalid, 1);
      check("mr_arid", axi.arid, INST_ID);
      @(posedge aclk); #1;
      @(negedge aclk);
      check("mr_rready", axi.rready, 1);
      #1;
      aresetn = 1'b0;
      axi.rvalid = 1'b1; axi.rid = INST_ID; axi.rdata = 32'hDEAD_BEEF; axi.rlast = 1'b1;
      #1;
      check("mr_rst_valids", {axi.arvalid, axi.rready}, 0);
      check("mr_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      axi.rvalid = 1'b0; axi.rlast = 1'b0;

      // fresh fetch after release: rvalid in cycle 3
      @(posedge aclk); #1;
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
      @(negedge aclk);
      check("ff_addr_ok_c0", inst_addr_ok, 1);
      check("ff_arvalid_c0", axi.arvalid, 0);
      @(posedge aclk); #1;
      inst_req = 1'b0;
      @(negedge aclk);
      check("ff_arvalid_c1", axi.arvalid, 1);
      check("ff_ar_c1", {axi.arid, axi.araddr}, {INST_ID, 32'hBFC0_0000});
      @(posedge aclk); #1;
      @(negedge aclk);
      check("ff_data_ok_c2", inst_data_ok, 0);
      @(posedge aclk); #1;
      axi.rvalid = 1'b1; axi.rid = INST_ID; axi.rdata = 32'h3C08_BFAF; axi.rlast = 1'b1;
      @(negedge aclk);
      check("ff_data_ok_c3", inst_data_ok, 1);
      check("ff_rdata_c3", inst_rdata, 32'h3C08_BFAF);
      check("ff_no_data_ok_c3", data_data_ok, 0);
      @(posedge aclk); #1;
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      @(negedge aclk);
      check("ff_data_ok_c4", inst_data_ok, 0);
      check("ff_rready_c4", axi.rready, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_req_arbiter.md
# axi_req_arbiter

Two-port-to-AXI3 master arbiter between the CPU core's instruction-fetch and data-access ports and the single AXI master interface exported at the CPU top level. It serialises requests from the two ports onto the AR/R and AW/W/B channels, with data reads prioritised over fetches. It allows at most one outstanding transaction per channel and per port.

## Interface

Parameters:
- INST_ID, default 4'd0: arid used for fetch reads.
- DATA_ID, default 4'd1: arid and awid used for data accesses.

Ports:
- aclk, input, 1: clock. All logic is on the rising edge.
- aresetn, input, 1: asynchronous, active-low reset.
- inst_req, input, 1: fetch request (read only).
- inst_size, input, 2: access size, log2 of bytes.
- inst_addr, input, 32: fetch address.
- inst_addr_ok, output, 1: request accepted this cycle.
- inst_data_ok, output, 1: read data valid this cycle (1-cycle pulse).
- inst_rdata, output, 32: fetch data, valid with inst_data_ok.
- data_req, input, 1: data request.
- data_wr, input, 1: 1 = write, 0 = read.
- data_size, input, 2: access size.
- data_addr, input, 32: access address.
- data_wstrb, input, 4: write byte strobes.
- data_wdata, input, 32: write data.
- data_addr_ok, output, 1: request accepted this cycle.
- data_data_ok, output, 1: read data returned or write response received (1-cycle pulse).
- data_rdata, output, 32: read data, valid with data_data_ok.
- arid/araddr/arsize/arvalid, outputs, 4/32/3/1: AR channel; arready is an input.
- Fixed AR/AW fields, outputs: arlen/awlen = 0, arburst/awburst = 2'b01, arlock/awlock = 0, arcache/awcache = 0, arprot/awprot = 0.
- rid/rdata/rresp/rlast/rvalid, inputs, 4/32/2/1/1: R channel; rready is an output.
- awid/awaddr/awsize/awvalid, outputs, 4/32/3/1: AW channel; awready is an input.
- wid/wdata/wstrb/wlast/wvalid, outputs, 4/32/4/1/1: W channel; wid = DATA_ID, wlast = 1. wready is an input.
- bid/bresp/bvalid, inputs, 4/2/1: B channel; bready is an output.

## Operation

- Read FSM states: R_IDLE, R_AR, R_WAIT.
  - R_IDLE -> R_AR on accepting a read. The accepted address, size and ID are captured into registers.
  - R_AR: arvalid = 1. Moves to R_WAIT on arready.
  - R_WAIT: rready = 1. Moves to R_IDLE on rvalid && rlast.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE -> W_ADDR on accepting a write. Address, size, strobes and data are captured.
  - W_ADDR: awvalid and wvalid are both asserted. Each drops independently on its own ready. Moves to W_RESP once both handshakes have completed; they may complete in the same or in different cycles.
  - W_RESP: bready = 1. Moves to W_IDLE on bvalid.
- Acceptance rules:
  - data_addr_ok = data_req && no data transaction outstanding on either channel && (data_wr ? W_IDLE : R_IDLE).
  - inst_addr_ok = inst_req && R_IDLE && no fetch outstanding && !(data_req && !data_wr && data_addr_ok).
  - Priority: a data read wins over a simultaneous fetch. A data write and a fetch can both be accepted in the same cycle.
- arsize/awsize = {1'b0, size}.
- Read return routing:
  - rid == DATA_ID: drives data_data_ok, with data_rdata = rdata.
  - Otherwise: drives inst_data_ok, with inst_rdata = rdata.
  - The rdata pass-through is combinational.
- Write completion: data_data_ok pulses in the cycle bvalid && bready.
- Ordering: a port holds at most one outstanding request, so responses return in request order per port. A data read cannot overtake a pending data write.
- rresp and bresp are ignored.

## Timing

- Reset values: all *valid, rready, bready, *_addr_ok and *_data_ok are 0. All captured address/ID/data registers are 0. Both FSMs are in IDLE.
- addr_ok is combinational in the request cycle (cycle 0). arvalid/awvalid are registered and first high in cycle 1.
- Minimum read latency: AR handshake in cycle 1, rvalid in cycle 2, so data_ok in cycle 2.
- Minimum write latency: AW and W handshakes in cycle 1, bvalid in cycle 2, so data_data_ok in cycle 2.
- Back-to-back: a new read can be accepted in the same cycle the previous R beat completes. addr_ok is then evaluated on the next-state IDLE, so the new request is accepted in that R-beat cycle.
- arvalid/awvalid/wvalid hold stable, with stable payload, until their respective ready.
- aresetn asserted mid-transaction:
  - All valids drop immediately and both FSMs return to IDLE.
  - No data_ok is generated for the aborted transaction.

## Test plan

- Single fetch: inst_req with inst_addr = 0xBFC00000 and arready = 1.
  - inst_addr_ok in cycle 0; arvalid with arid = 0 in cycle 1.
  - rvalid with rdata = 0x3C08BFAF in cycle 3 -> inst_data_ok with inst_rdata = 0x3C08BFAF in cycle 3.
- Simultaneous data read (0x80001000) and fetch:
  - Only data_addr_ok is asserted; araddr = 0x80001000 with arid = 1.
  - inst_addr_ok rises in the cycle the data R beat completes.
- Write with arbitrary readiness: data write to 0x80002004 with wstrb = 4'b0011, where wready arrives 3 cycles after awready.
  - awvalid drops after its handshake while wvalid holds.
  - bvalid -> data_data_ok pulse for exactly 1 cycle.
- Data read request while a data write is outstanding -> data_addr_ok stays 0 until the cycle after the write's data_data_ok.
- Concurrent fetch and data write in the same cycle -> both addr_ok asserted; AR and AW are issued in the same cycle 1.
- aresetn pulled low while in R_WAIT -> arvalid, rready and data_ok are 0. After release, a fresh fetch completes normally.
